rr_arbiter16: RTL and testbench
===============================

Name: rr_arbiter16

Overview:
- Round-robin arbiter that shares one resource among 16 requesters.
- Its output is a registered one-hot grant plus the winner's 4-bit index, so downstream steering logic can select the requester's datapath directly.
- Adds fairness, grant hold and an optional hold timeout on top of the team's combinational 16-to-4 priority encoding.

Parameters:
- N, 16, number of requesters; fixed at 16 for this revision.
- IDW, 4, index width, log2(N).
- MAX_HOLD, 0, maximum consecutive grant cycles per requester; 0 means unlimited.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- en  in  1  arbiter enable.
- req  in  16  request vector; bit i high means requester i wants the resource.
- gnt  out  16  registered one-hot grant; all zeros when no grant is active.
- gnt_id  out  4  index of the granted requester; 0 when there is no grant.
- gnt_valid  out  1  high while any grant is active; equals OR of gnt.
- timeout  out  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset values (asynchronous, immediate on rst high):
  - outputs: gnt=0, gnt_id=0, gnt_valid=0, timeout=0.
  - internal: priority pointer ptr=0, hold_cnt=0, state=IDLE.
- Search order: ptr, ptr+1, ..., 15, 0, ..., ptr-1, all modulo 16. The winner is the first asserted req bit in that order.
- State IDLE:
  - If en=1 and req!=0 at a rising edge, register the winner into gnt/gnt_id, set gnt_valid=1, set hold_cnt=1 and go to GRANT.
  - Latency is 1 cycle from a sampled request to a visible grant.
  - Otherwise stay in IDLE with outputs at zero.
- State GRANT, evaluated at each edge with g=gnt_id:
  - en=0: clear the grant and go to IDLE. ptr is unchanged.
  - req[g]=0 (release): set ptr=(g+1) mod 16. In the same edge, re-arbitrate using the new ptr.
    - If any other req is set, gnt switches directly to the new winner with no idle cycle, and hold_cnt=1.
    - Else clear the grant and go to IDLE.
  - MAX_HOLD>0 and hold_cnt==MAX_HOLD with req[g]=1 (timeout): pulse timeout=1 for the next cycle, set ptr=(g+1) mod 16, and re-arbitrate exactly as for a release.
    - g competes again at lowest priority.
    - If g is the only requester it is re-granted, with the gnt bit staying high and hold_cnt reset to 1.
  - Otherwise hold the grant and increment hold_cnt. hold_cnt saturates and never wraps; its width is sized for MAX_HOLD.
  - As a result, a grant is visible for exactly MAX_HOLD cycles before a timeout.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_id always equals the encoded position of gnt.
  - gnt never changes while the holder's req stays high and no timeout or en=0 occurs.
  - Changes to req of non-holders never affect the current grant.
- Simultaneous events:
  - Release and timeout at the same edge: treat as a release, so no timeout pulse.
  - en=0 together with a release: en=0 wins, and ptr is not advanced.
- Boundaries:
  - Pointer wrap: g=15 releases, so ptr becomes 0.
  - req=16'hFFFF with unlimited hold and cooperative release: grants cycle 0,1,2,...,15,0.
- Reset mid-grant: gnt drops asynchronously and ptr returns to 0. After reset release, the first grant follows from ptr=0.

Test Plan:
- Reset, then req=16'h0000 for 5 cycles -> gnt=0, gnt_valid=0, gnt_id=0 throughout.
- req=16'h0024 applied while ptr=0 -> one cycle later gnt=16'h0004 and gnt_id=2. Drop req[2] -> next edge gnt=16'h0020, gnt_id=5, no idle cycle.
- req=16'hFFFF held; each holder drops its bit 3 cycles after grant and re-asserts it the next cycle -> gnt_id sequence 0,1,...,15,0 with no skips or repeats.
- MAX_HOLD=4, req=16'h8001 held forever -> gnt_id=0 for 4 cycles, timeout pulse, gnt_id=15 for 4 cycles, timeout pulse, then gnt_id=0 again.
- Grant held at gnt_id=7 -> deassert en for 1 cycle: gnt=0. Re-assert en with req=16'h0180 -> gnt_id=7 again, because ptr was not advanced.
- Assert rst asynchronously mid-cycle while gnt_id=9 -> gnt=0 immediately, before the next clock edge. After release with req=16'h0600 -> gnt_id=9, the first set bit scanning from ptr=0.

Source files
------------

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter for 16 requesters with a registered one-hot grant,
// encoded winner index, grant hold and an optional hold timeout.
module rr_arbiter16 #(
  parameter int N        = 16,
  parameter int IDW      = 4,
  parameter int MAX_HOLD = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid,
  output logic           timeout
);

  localparam int HCW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HCW-1:0] HOLD_LIMIT = HCW'(MAX_HOLD);
  localparam logic [N-1:0]   ONE_HOT0   = N'(1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state_reg;
  logic [IDW-1:0] ptr_reg;
  logic [HCW-1:0] hold_cnt_reg;

  logic [IDW-1:0] start;
  logic [N-1:0]   req_rot;
  logic [IDW-1:0] off;
  logic [IDW-1:0] win_id;
  logic           found;
  logic           holder_req;
  logic           hold_expired;

  // While granting, the only re-arbitration ever used starts just past the holder.
  assign start = (state_reg == GRANT) ? gnt_id + 1'b1 : ptr_reg;

  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    assign req_rot[gi] = req[IDW'(gi) + start];
  end

  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        found = 1'b1;
        off   = IDW'(i);
      end
    end
  end

  assign win_id       = start + off;
  assign holder_req   = req[gnt_id];
  assign hold_expired = (MAX_HOLD > 0) && (hold_cnt_reg == HOLD_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      hold_cnt_reg <= '0;
      gnt          <= '0;
      gnt_id       <= '0;
      gnt_valid    <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (en && found) begin
            gnt          <= ONE_HOT0 << win_id;
            gnt_id       <= win_id;
            gnt_valid    <= 1'b1;
            hold_cnt_reg <= HCW'(1);
            state_reg    <= GRANT;
          end
        end
        GRANT: begin
          if (!en) begin
            gnt          <= '0;
            gnt_id       <= '0;
            gnt_valid    <= 1'b0;
            hold_cnt_reg <= '0;
            state_reg    <= IDLE;
          end else if (!holder_req || hold_expired) begin
            // A release takes precedence, so the pulse only marks a forced revoke.
            ptr_reg <= gnt_id + 1'b1;
            if (holder_req) begin
              timeout <= 1'b1;
            end
            if (found) begin
              gnt          <= ONE_HOT0 << win_id;
              gnt_id       <= win_id;
              hold_cnt_reg <= HCW'(1);
            end else begin
              gnt          <= '0;
              gnt_id       <= '0;
              gnt_valid    <= 1'b0;
              hold_cnt_reg <= '0;
              state_reg    <= IDLE;
            end
          end else if (hold_cnt_reg != '1) begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter16.sv
// Bench for rr_arbiter16: an unlimited-hold and a MAX_HOLD=4 instance share
// stimulus and are compared every cycle against an integer reference model.
module tb_rr_arbiter16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en  = 1'b0;
  logic [15:0]      req = '0;
  logic [1:0][15:0] gnt_o;
  logic [1:0][3:0]  id_o;
  logic [1:0]       v_o;
  logic [1:0]       to_o;

  int total = 0;
  int bad   = 0;

  int holder [2];
  int mptr   [2];
  int mcnt   [2];
  bit mto    [2];
  int maxh   [2] = '{0, 4};

  always #5 clk = ~clk;

  rr_arbiter16 #(.N(16), .IDW(4), .MAX_HOLD(0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(gnt_o[0]), .gnt_id(id_o[0]), .gnt_valid(v_o[0]), .timeout(to_o[0])
  );

  rr_arbiter16 #(.N(16), .IDW(4), .MAX_HOLD(4)) dut_b (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(gnt_o[1]), .gnt_id(id_o[1]), .gnt_valid(v_o[1]), .timeout(to_o[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First requester found scanning start, start+1, ... modulo 16.
  function automatic int pick(input int start, input logic [15:0] r);
    for (int i = 0; i < 16; i++) begin
      if (r[(start + i) % 16]) return (start + i) % 16;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      holder[k] = -1; mptr[k] = 0; mcnt[k] = 0; mto[k] = 1'b0;
    end
  endtask

  task automatic model_update();
    if (rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      mto[k] = 1'b0;
      if (holder[k] < 0) begin
        if (en && req != 0) begin
          holder[k] = pick(mptr[k], req);
          mcnt[k]   = 1;
        end
      end else if (!en) begin
        holder[k] = -1;
        mcnt[k]   = 0;
      end else if (!req[holder[k]] || (maxh[k] > 0 && mcnt[k] >= maxh[k])) begin
        if (req[holder[k]]) mto[k] = 1'b1;
        mptr[k]   = (holder[k] + 1) % 16;
        holder[k] = pick(mptr[k], req);
        mcnt[k]   = (holder[k] < 0) ? 0 : 1;
      end else begin
        mcnt[k]++;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      logic [15:0] eg;
      logic [3:0]  eid;
      eg  = (holder[k] < 0) ? 16'h0 : (16'h1 << holder[k]);
      eid = (holder[k] < 0) ? 4'd0 : 4'(holder[k]);
      chk($sformatf("gnt[%0d]", k), 32'(gnt_o[k]), 32'(eg));
      chk($sformatf("gnt_id[%0d]", k), 32'(id_o[k]), 32'(eid));
      chk($sformatf("gnt_valid[%0d]", k), 32'(v_o[k]), 32'(holder[k] >= 0));
      chk($sformatf("timeout[%0d]", k), 32'(to_o[k]), 32'(mto[k]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
    $display("t=%0t rst=%0b en=%0b req=%04h | a: id=%0d v=%0b to=%0b | b: id=%0d v=%0b to=%0b",
             $time, rst, en, req, id_o[0], v_o[0], to_o[0], id_o[1], v_o[1], to_o[1]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    // Reset, then idle requests.
    cycle();
    cycle();
    rst = 1'b0;
    en  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("idle_gnt", 32'(gnt_o[0]), 32'h0);
    end

    // Basic grant and back-to-back hand-off.
    req = 16'h0024;
    cycle();
    chk("first_grant_id", 32'(id_o[0]), 32'd2);
    req = 16'h0020;
    cycle();
    chk("handoff_id", 32'(id_o[0]), 32'd5);
    chk("handoff_valid", 32'(v_o[0]), 32'd1);
    req = 16'h0000;
    cycle();

    // Full rotation with cooperative release, including the 15 -> 0 wrap.
    do_reset();
    req = 16'hFFFF;
    cycle();
    chk("rot_start", 32'(id_o[0]), 32'd0);
    for (int i = 0; i < 16; i++) begin
      cycle();
      cycle();
      req = 16'hFFFF ^ (16'h1 << id_o[0]);
      cycle();
      chk($sformatf("rot_%0d", i), 32'(id_o[0]), 32'((i + 1) % 16));
      req = 16'hFFFF;
    end

    // Hold timeout on instance b.
    en = 1'b0; req = 16'h0;
    cycle();
    do_reset();
    en  = 1'b1;
    req = 16'h8001;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("to_hold0", 32'(id_o[1]), 32'd0);
    end
    cycle();
    chk("to_pulse1", 32'(to_o[1]), 32'd1);
    chk("to_id15", 32'(id_o[1]), 32'd15);
    for (int i = 0; i < 3; i++) cycle();
    cycle();
    chk("to_pulse2", 32'(to_o[1]), 32'd1);
    chk("to_id0", 32'(id_o[1]), 32'd0);
    chk("no_to_unlimited", 32'(to_o[0]), 32'd0);

    // en=0 drops the grant without moving the pointer.
    en = 1'b0; req = 16'h0;
    cycle();
    do_reset();
    en  = 1'b1;
    req = 16'h0080;
    cycle();
    chk("en_grant7", 32'(id_o[0]), 32'd7);
    en = 1'b0;
    cycle();
    chk("en_off_gnt", 32'(gnt_o[0]), 32'h0);
    en  = 1'b1;
    req = 16'h0180;
    cycle();
    chk("en_back7", 32'(id_o[0]), 32'd7);

    // Asynchronous reset while holding grant 9.
    req = 16'h0200;
    cycle();
    chk("pre_rst9", 32'(id_o[0]), 32'd9);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_gnt", 32'(gnt_o[0]), 32'h0);
    chk("async_rst_valid", 32'(v_o[1]), 32'd0);
    model_reset();
    cycle();
    rst = 1'b0;
    req = 16'h0600;
    cycle();
    chk("post_rst9", 32'(id_o[0]), 32'd9);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 15) != 0);
      case ($urandom_range(0, 3))
        0: req = 16'($urandom) & 16'($urandom) & 16'($urandom);
        1: req = 16'($urandom);
        2: if (v_o[0]) req = req & ~(16'h1 << id_o[0]);
        default: req = req | (16'h1 << $urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 7) == 0) req = 16'h0;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
